status_register_stack: RTL and testbench

- Parametrised successor to the core's single NZCV flag register.
- Holds the live condition flags and supports per-bit masked writes.
- Has a LIFO shadow stack of saved flag words. Exception entry pushes the live flags; exception return pops them back, SPSR-style, and nesting is allowed up to DEPTH.
- Sits between the ALU flag outputs and the condition-check logic in the execute stage.

---
 rtl/status_register_stack.sv | 114 +++++++++++
 tb/tb_status_register_stack.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/status_register_stack.sv
// Live condition-flag register with masked writes and a LIFO shadow stack for
// exception nesting. Optional: STATUS_REGISTER_STACK_COND_EVAL_EN adds ARM condition evaluation.
module status_register_stack #(
  parameter int FLAG_W = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [FLAG_W-1:0] mask,
  input  logic [FLAG_W-1:0] d_in,
  input  logic              push,
  input  logic              pop,
  input  logic              err_clr,
`ifdef STATUS_REGISTER_STACK_COND_EVAL_EN
  input  logic [3:0]        cond,
  output logic              cond_pass,
`endif
  output logic [FLAG_W-1:0] d_out,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [FLAG_W-1:0] stack [DEPTH];
  logic [CNT_W-1:0]  count_m1;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              do_push;
  logic              do_pop;
  logic              misuse;
  logic [FLAG_W-1:0] written;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign count_m1 = count - ONE_C;
  assign wr_idx   = count[IDX_W-1:0];
  assign rd_idx   = count_m1[IDX_W-1:0];

  // push and pop together is illegal, so neither takes effect.
  assign do_push = push & ~pop & ~full;
  assign do_pop  = pop & ~push & ~empty;
  assign misuse  = (push & pop) | (push & ~pop & full) | (pop & ~push & empty);
  assign written = (d_out & ~mask) | (d_in & mask);

  always_ff @(negedge clk) begin
    if (rst) begin
      d_out <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      // A pop restores the saved word and discards any same-edge write.
      if (do_pop) begin
        d_out <= stack[rd_idx];
      end else if (en) begin
        d_out <= written;
      end

      if (do_push) begin
        count <= count + ONE_C;
      end else if (do_pop) begin
        count <= count_m1;
      end

      if (misuse) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

  // Stack contents need no reset; they are never observable while empty.
  always_ff @(negedge clk) begin
    if (!rst && do_push) begin
      stack[wr_idx] <= d_out;
    end
  end

`ifdef STATUS_REGISTER_STACK_COND_EVAL_EN
  logic flag_n, flag_z, flag_c, flag_v;

  assign {flag_n, flag_z, flag_c, flag_v} = d_out[FLAG_W-1 -: 4];

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = ~flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = ~flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = ~flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = ~flag_v;
      4'b1000: cond_pass = flag_c & ~flag_z;
      4'b1001: cond_pass = ~flag_c | flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_pass = flag_z | (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end
`endif

endmodule

// File: tb/tb_status_register_stack.sv
// Directed bench for status_register_stack: each step queues its expected
// {d_out, count, err} and the word is popped and compared after the falling edge.
module tb_status_register_stack;

  localparam int FLAG_W = 4;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int W      = FLAG_W + CNT_W + 1;

  logic              clk;
  logic              rst;
  logic              en;
  logic [FLAG_W-1:0] mask;
  logic [FLAG_W-1:0] d_in;
  logic              push;
  logic              pop;
  logic              err_clr;
  logic [FLAG_W-1:0] d_out;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              err;
`ifdef STATUS_REGISTER_STACK_COND_EVAL_EN
  logic [3:0]        cond;
  logic              cond_pass;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  status_register_stack #(.FLAG_W(FLAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .mask(mask),
    .d_in(d_in),
    .push(push),
    .pop(pop),
    .err_clr(err_clr),
`ifdef STATUS_REGISTER_STACK_COND_EVAL_EN
    .cond(cond),
    .cond_pass(cond_pass),
`endif
    .d_out(d_out),
    .count(count),
    .full(full),
    .empty(empty),
    .err(err)
  );

  // Clock / reset
  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Driver: one falling edge with the given inputs, then score the outputs.
  task automatic step(input string tag,
                      input logic r, input logic e, input logic [3:0] m, input logic [3:0] d,
                      input logic pu, input logic po, input logic ec,
                      input logic [3:0] exp_d, input int exp_cnt, input logic exp_err);
    logic [W-1:0] got;
    logic [FLAG_W-1:0] ed;
    logic [CNT_W-1:0]  ec_n;
    logic              ee;
    @(posedge clk);
    rst = r; en = e; mask = m; d_in = d; push = pu; pop = po; err_clr = ec;
    exp_q.push_back({exp_d, CNT_W'(exp_cnt), exp_err});
    @(negedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard underflow observed=0 expected=1", tag);
    end else begin
      got = exp_q.pop_front();
      {ed, ec_n, ee} = got;
      check({tag, ".d_out"}, 8'(d_out), 8'(ed));
      check({tag, ".count"}, 8'(count), 8'(ec_n));
      check({tag, ".err"},   8'(err),   8'(ee));
      check({tag, ".full"},  8'(full),  8'(ec_n == CNT_W'(DEPTH)));
      check({tag, ".empty"}, 8'(empty), 8'(ec_n == '0));
    end
    rst = 0; en = 0; mask = 0; d_in = 0; push = 0; pop = 0; err_clr = 0;
  endtask

  initial begin
    rst = 0; en = 0; mask = 0; d_in = 0; push = 0; pop = 0; err_clr = 0;
`ifdef STATUS_REGISTER_STACK_COND_EVAL_EN
    cond = 4'b0000;
`endif
    //    tag        rst en mask   d_in   pu po ec   exp_d  cnt err
    step("reset",    1, 0, 4'h0, 4'h0, 0, 0, 0,   4'h0, 0, 0);
    step("mwr_a",    0, 1, 4'hA, 4'hF, 0, 0, 0,   4'hA, 0, 0);
    step("mwr_5",    0, 1, 4'h5, 4'h0, 0, 0, 0,   4'hA, 0, 0);
    step("mask0",    0, 1, 4'h0, 4'h5, 0, 0, 0,   4'hA, 0, 0);
    step("set6",     0, 1, 4'hF, 4'h6, 0, 0, 0,   4'h6, 0, 0);
    step("push_wr",  0, 1, 4'hF, 4'h9, 1, 0, 0,   4'h9, 1, 0);
    step("pop_rt",   0, 0, 4'h0, 4'h0, 0, 1, 0,   4'h6, 0, 0);
    // Nesting to full: pushed words are the pre-write values 1,2,3,4.
    step("set1",     0, 1, 4'hF, 4'h1, 0, 0, 0,   4'h1, 0, 0);
    step("nest1",    0, 1, 4'hF, 4'h2, 1, 0, 0,   4'h2, 1, 0);
    step("nest2",    0, 1, 4'hF, 4'h3, 1, 0, 0,   4'h3, 2, 0);
    step("nest3",    0, 1, 4'hF, 4'h4, 1, 0, 0,   4'h4, 3, 0);
    step("nest4",    0, 1, 4'hF, 4'h5, 1, 0, 0,   4'h5, 4, 0);
    step("push_ful", 0, 1, 4'hF, 4'h7, 1, 0, 0,   4'h7, 4, 1);
    step("unnest4",  0, 0, 4'h0, 4'h0, 0, 1, 0,   4'h4, 3, 1);
    step("unnest3",  0, 0, 4'h0, 4'h0, 0, 1, 0,   4'h3, 2, 1);
    step("unnest2",  0, 0, 4'h0, 4'h0, 0, 1, 0,   4'h2, 1, 1);
    step("unnest1",  0, 0, 4'h0, 4'h0, 0, 1, 0,   4'h1, 0, 1);
    step("clr1",     0, 0, 4'h0, 4'h0, 0, 0, 1,   4'h1, 0, 0);
    // Misuse
    step("pop_emp",  0, 1, 4'hF, 4'h8, 0, 1, 0,   4'h8, 0, 1);
    step("pushpop",  0, 0, 4'h0, 4'h0, 1, 1, 0,   4'h8, 0, 1);
    step("clr2",     0, 0, 4'h0, 4'h0, 0, 0, 1,   4'h8, 0, 0);
    step("clr_set",  0, 0, 4'h0, 4'h0, 0, 1, 1,   4'h8, 0, 1);
    step("clr3",     0, 0, 4'h0, 4'h0, 0, 0, 1,   4'h8, 0, 0);
    step("pp_wr",    0, 1, 4'h3, 4'h3, 1, 1, 0,   4'hB, 0, 1);
    step("clr4",     0, 0, 4'h0, 4'h0, 0, 0, 1,   4'hB, 0, 0);
    // Pop discards a same-edge write.
    step("push_b",   0, 0, 4'h0, 4'h0, 1, 0, 0,   4'hB, 1, 0);
    step("set2",     0, 1, 4'hF, 4'h2, 0, 0, 0,   4'h2, 1, 0);
    step("pop_wr",   0, 1, 4'hF, 4'hF, 0, 1, 0,   4'hB, 0, 0);
    // Reset mid-operation
    step("fill1",    0, 0, 4'h0, 4'h0, 1, 0, 0,   4'hB, 1, 0);
    step("fill2",    0, 0, 4'h0, 4'h0, 1, 0, 0,   4'hB, 2, 0);
    step("fill3",    0, 1, 4'hF, 4'hC, 1, 0, 0,   4'hC, 3, 0);
    step("err_mid",  0, 0, 4'h0, 4'h0, 1, 1, 0,   4'hC, 3, 1);
    step("rst_mid",  1, 1, 4'hF, 4'hF, 1, 0, 0,   4'h0, 0, 0);
    step("post_rst", 0, 0, 4'h0, 4'h0, 0, 1, 0,   4'h0, 0, 1);

`ifdef STATUS_REGISTER_STACK_COND_EVAL_EN
    step("set9",     0, 1, 4'hF, 4'h9, 0, 0, 0,   4'h9, 0, 1);
    cond = 4'b1010; #1; check("cond_ge",  8'(cond_pass), 8'd1);
    cond = 4'b1011; #1; check("cond_lt",  8'(cond_pass), 8'd0);
    cond = 4'b1100; #1; check("cond_gt",  8'(cond_pass), 8'd1);
    cond = 4'b0000; #1; check("cond_eq",  8'(cond_pass), 8'd0);
    cond = 4'b0001; #1; check("cond_ne",  8'(cond_pass), 8'd1);
    cond = 4'b0100; #1; check("cond_mi",  8'(cond_pass), 8'd1);
    cond = 4'b1000; #1; check("cond_hi",  8'(cond_pass), 8'd0);
    cond = 4'b1110; #1; check("cond_al",  8'(cond_pass), 8'd1);
    cond = 4'b1111; #1; check("cond_nv",  8'(cond_pass), 8'd0);
    step("set6c",    0, 1, 4'hF, 4'h6, 0, 0, 0,   4'h6, 0, 1);
    cond = 4'b0000; #1; check("cond_eq6", 8'(cond_pass), 8'd1);
    cond = 4'b1001; #1; check("cond_ls6", 8'(cond_pass), 8'd1);
    cond = 4'b1101; #1; check("cond_le6", 8'(cond_pass), 8'd1);
    cond = 4'b0110; #1; check("cond_vs6", 8'(cond_pass), 8'd0);
`endif

    // Final report
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
